// File: rtl/stream_packetizer.sv
`default_nettype none
// ============================================================================
// stream_packetizer: cuts a beat stream into packets of at most MAX_PKT_LEN,
// closing idle partial packets after TIMEOUT cycles.      Rev 1.0
// ============================================================================
module stream_packetizer #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_PKT_LEN = 16,
  parameter int TIMEOUT     = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [15:0]           pkt_count,
  output logic [15:0]           timeout_count
);

  localparam int c_idx_w  = $clog2(MAX_PKT_LEN);
  localparam int c_idle_w = $clog2(TIMEOUT);
  localparam logic [c_idx_w-1:0]  c_idx_last = c_idx_w'(MAX_PKT_LEN - 1);
  localparam logic [c_idle_w-1:0] c_idle_max = c_idle_w'(TIMEOUT - 1);

  logic [DATA_WIDTH-1:0] r_h_data;
  logic                  r_h_v;
  logic                  r_h_last;
  logic [c_idx_w-1:0]    r_idx;
  logic [c_idle_w-1:0]   r_idle;

  logic w_o_free;
  logic w_accept;
  logic w_idle_hit;
  logic w_new_last;
  logic w_move;
  logic w_move_last;
  logic w_timeout;

  always_comb begin
    w_o_free    = !m_tvalid || m_tready;
    s_tready    = !r_h_v || w_o_free;
    w_accept    = s_tvalid && s_tready;
    w_idle_hit  = (r_idle == c_idle_max);
    w_new_last  = s_tlast || (r_idx == c_idx_last);
    w_move      = r_h_v && w_o_free && (w_accept || r_h_last || w_idle_hit);
    // A beat arriving on the timeout cycle wins: the held beat keeps its own end flag.
    w_move_last = w_accept ? r_h_last : 1'b1;
    w_timeout   = r_h_v && !r_h_last && w_o_free && w_idle_hit && !w_accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_data      <= '0;
      r_h_v         <= 1'b0;
      r_h_last      <= 1'b0;
      r_idx         <= '0;
      r_idle        <= '0;
      m_tdata       <= '0;
      m_tvalid      <= 1'b0;
      m_tlast       <= 1'b0;
      pkt_count     <= '0;
      timeout_count <= '0;
    end else begin
      if (w_accept) begin
        r_h_data <= s_tdata;
        r_h_last <= w_new_last;
        r_h_v    <= 1'b1;
        r_idx    <= w_new_last ? '0 : r_idx + c_idx_w'(1);
      end else if (w_move) begin
        r_h_v <= 1'b0;
      end

      if (w_timeout) begin
        r_idx         <= '0;
        timeout_count <= timeout_count + 16'd1;
      end

      if (w_accept || !r_h_v) begin
        r_idle <= '0;
      end else if (!r_h_last && !w_idle_hit) begin
        r_idle <= r_idle + c_idle_w'(1);
      end

      if (w_move) begin
        m_tvalid <= 1'b1;
        m_tdata  <= r_h_data;
        m_tlast  <= w_move_last;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end

      if (m_tvalid && m_tready && m_tlast) begin
        pkt_count <= pkt_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_packetizer.sv
`default_nettype none
// ============================================================================
// tb_stream_packetizer: directed and random stimulus against a queue-based
// packet model of stream_packetizer.                      Rev 1.0
// ============================================================================
module tb_stream_packetizer;

  localparam int DW   = 32;
  localparam int MAXL = 16;
  localparam int TO   = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic [15:0]   pkt_count;
  logic [15:0]   timeout_count;

  stream_packetizer #(
    .DATA_WIDTH (DW),
    .MAX_PKT_LEN(MAXL),
    .TIMEOUT    (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tlast      (s_tlast),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .pkt_count    (pkt_count),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t       exp_q[$];
  int          asserts = 0;
  int          fails   = 0;
  int          cyc     = 0;
  int          in_cyc  = 0;
  int          out_cyc = 0;
  int          pos     = 0;
  logic [15:0] exp_pkts = '0;
  logic [15:0] exp_to   = '0;
  bit          hs_in;
  bit          prev_stall = 0;
  logic [DW-1:0] prev_d;
  logic        prev_l;
  bit          saw_not_ready = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    asserts++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // One clock cycle: observe settled signals at the falling edge, update the model.
  task automatic cycle();
    beat_t b;
    @(negedge clk);
    cyc++;
    hs_in = 0;
    if (!rst) begin
      check("s_tready", s_tready, !(exp_q.size() == 2 && !m_tready));
      if (!s_tready) saw_not_ready = 1;
      if (prev_stall) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_data", m_tdata, prev_d);
        check("hold_last", m_tlast, prev_l);
      end
      if (m_tvalid && m_tready) begin
        check("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          check("out_data", m_tdata, b.d);
          check("out_last", m_tlast, b.l);
          if (b.l) exp_pkts++;
          out_cyc = cyc;
        end
      end
      if (s_tvalid && s_tready) begin
        b.d = s_tdata;
        b.l = s_tlast || (pos == MAXL - 1);
        pos = b.l ? 0 : pos + 1;
        exp_q.push_back(b);
        hs_in  = 1;
        in_cyc = cyc;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d     = m_tdata;
      prev_l     = m_tlast;
    end else begin
      prev_stall = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    do begin
      cycle();
      n++;
    end while (!hs_in && n < 2000);
    if (!hs_in) check("send_timeout", hs_in, 1);
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) cycle();
  endtask

  // The open packet's newest beat is about to be closed by the idle timer.
  task automatic expect_timeout();
    beat_t b;
    if (exp_q.size() > 0 && !exp_q[exp_q.size()-1].l) begin
      b   = exp_q.pop_back();
      b.l = 1'b1;
      exp_q.push_back(b);
      exp_to++;
      pos = 0;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    #1;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_timeout_count", timeout_count, 0);
    check("rst_s_tready", s_tready, 1);
    repeat (2) cycle();
    rst = 1'b0;
    exp_q.delete();
    pos        = 0;
    exp_pkts   = '0;
    exp_to     = '0;
    prev_stall = 0;
  endtask

  initial begin
    int first_in;
    int k;
    int gap;
    int n;

    #2;
    do_reset();

    // Length cut at MAX_PKT_LEN, then timeout close of the 8-beat tail.
    m_tready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_beat(DW'(i), 1'b0);
      if (i == 0) first_in = in_cyc;
    end
    check("throughput", in_cyc - first_in, 39);
    expect_timeout();
    idle(TO + 10);
    check("timeout_latency", out_cyc - in_cyc, TO + 1);
    check("cut_drained", exp_q.size(), 0);
    check("cut_pkt_count", pkt_count, exp_pkts);
    check("cut_pkt_count_3", pkt_count, 3);
    check("cut_timeout_count", timeout_count, exp_to);

    // Upstream end request closes without waiting.
    send_beat(32'hA, 1'b0);
    send_beat(32'hB, 1'b0);
    send_beat(32'hC, 1'b1);
    idle(4);
    check("tlast_drained", exp_q.size(), 0);
    check("tlast_timeout_count", timeout_count, exp_to);
    check("tlast_pkt_count", pkt_count, exp_pkts);

    // Arrival on the last idle cycle beats the timeout.
    send_beat(32'hC0, 1'b0);
    idle(TO - 1);
    send_beat(32'hD0, 1'b0);
    idle(2);
    check("tie_timeout_count", timeout_count, exp_to);
    check("tie_held", exp_q.size(), 1);
    expect_timeout();
    idle(TO + 10);
    check("tie_drained", exp_q.size(), 0);
    check("tie_timeout_after", timeout_count, exp_to);

    // Back-pressure inside a 16-beat burst.
    saw_not_ready = 0;
    for (int i = 0; i < 4; i++) send_beat(32'h100 + DW'(i), 1'b0);
    m_tready = 1'b0;
    k        = 4;
    s_tvalid = 1'b1;
    s_tdata  = 32'h100 + DW'(k);
    s_tlast  = 1'b0;
    repeat (50) begin
      cycle();
      if (hs_in) begin
        k++;
        s_tdata = 32'h100 + DW'(k);
      end
    end
    m_tready = 1'b1;
    while (k < 16) begin
      send_beat(32'h100 + DW'(k), 1'b0);
      k++;
    end
    idle(5);
    check("bp_saw_not_ready", saw_not_ready, 1);
    check("bp_drained", exp_q.size(), 0);
    check("bp_pkt_count", pkt_count, exp_pkts);

    // Reset in the middle of a packet.
    for (int i = 0; i < 5; i++) send_beat(32'h200 + DW'(i), 1'b0);
    do_reset();
    idle(TO + 10);
    check("mid_rst_pkt_count", pkt_count, 0);
    check("mid_rst_timeout_count", timeout_count, 0);
    for (int i = 0; i < 16; i++) send_beat(32'h300 + DW'(i), 1'b0);
    idle(5);
    check("post_rst_drained", exp_q.size(), 0);
    check("post_rst_pkt_count", pkt_count, exp_pkts);

    // Random traffic with random downstream stalls.
    gap = 0;
    s_tvalid = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      m_tready = ($urandom_range(0, 9) < 7);
      if (!s_tvalid) begin
        if (gap >= 40 || $urandom_range(0, 1) == 1) begin
          s_tvalid = 1'b1;
          s_tdata  = $urandom;
          s_tlast  = ($urandom_range(0, 7) == 0);
          gap      = 0;
        end else begin
          gap++;
        end
      end
      cycle();
      if (hs_in) s_tvalid = 1'b0;
    end
    m_tready = 1'b1;
    n = 0;
    while (s_tvalid && n < 100) begin
      cycle();
      n++;
      if (hs_in) s_tvalid = 1'b0;
    end
    expect_timeout();
    idle(TO + 10);
    check("rand_drained", exp_q.size(), 0);
    check("rand_pkt_count", pkt_count, exp_pkts);
    check("rand_timeout_count", timeout_count, exp_to);

    // Packet counter wrap-around.
    do_reset();
    for (int i = 0; i < 65537; i++) send_beat(DW'(i), 1'b1);
    idle(5);
    check("wrap_drained", exp_q.size(), 0);
    check("wrap_pkt_count", pkt_count, exp_pkts);
    check("wrap_pkt_count_1", pkt_count, 1);
    check("wrap_timeout_count", timeout_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
`default_nettype wire
